// File: rtl/wb_write_arbiter.sv
// Writeback arbiter for the register bank write port: merges ALU results
// with queued load returns and tracks registers with loads outstanding.
module wb_write_arbiter #(
    parameter int LQ_DEPTH   = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid_i,
    input  logic [4:0]  alu_rd_i,
    input  logic [31:0] alu_data_i,
    output logic        alu_ready_o,
    input  logic        ld_valid_i,
    input  logic [4:0]  ld_rd_i,
    input  logic [31:0] ld_data_i,
    output logic        ld_ready_o,
    input  logic        pend_set_i,
    input  logic [4:0]  pend_rd_i,
    output logic [31:0] Wr_Data_o,
    output logic        Wr_Enable_o,
    output logic [4:0]  write_port_Addr_o,
    output logic [31:0] busy_mask_o
);

    localparam int PW = $clog2(LQ_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] FULL = CW'(LQ_DEPTH);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic [4:0]    lq_rd_q   [LQ_DEPTH];
    logic [31:0]   lq_data_q [LQ_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0]   busy_q, busy_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic [4:0]    wr_addr_q, wr_addr_d;
    logic          wr_en_q, wr_en_d;

    logic          full, empty, force_ld;
    logic          push, pop, take_alu;
    logic [4:0]    head_rd;
    logic [31:0]   head_data;

    always_comb begin
        full        = (count_q == FULL);
        empty       = (count_q == '0);
        force_ld    = full || (starve_q == SMAX);
        alu_ready_o = rst && !force_ld;
        ld_ready_o  = rst && !full;
        head_rd     = lq_rd_q[rd_ptr_q];
        head_data   = lq_data_q[rd_ptr_q];

        // A forced FIFO win blocks the ALU; otherwise the ALU has priority
        pop      = !empty && (force_ld || !alu_valid_i);
        take_alu = alu_valid_i && !force_ld;
        push     = ld_valid_i && !full;

        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);

        starve_d = starve_q;
        if (pop || empty) begin
            starve_d = '0;
        end else if (starve_q != SMAX) begin
            starve_d = starve_q + SW'(1);
        end

        busy_d = busy_q;
        if (pop) begin
            busy_d[head_rd] = 1'b0;
        end
        if (pend_set_i && (pend_rd_i != 5'd0)) begin
            busy_d[pend_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;

        wr_data_d = wr_data_q;
        wr_addr_d = wr_addr_q;
        wr_en_d   = 1'b0;
        if (take_alu) begin
            wr_data_d = alu_data_i;
            wr_addr_d = alu_rd_i;
            wr_en_d   = (alu_rd_i != 5'd0);
        end else if (pop) begin
            wr_data_d = head_data;
            wr_addr_d = head_rd;
            wr_en_d   = (head_rd != 5'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            lq_rd_q[wr_ptr_q]   <= ld_rd_i;
            lq_data_q[wr_ptr_q] <= ld_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            busy_q    <= '0;
            wr_data_q <= '0;
            wr_addr_q <= '0;
            wr_en_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            busy_q    <= busy_d;
            wr_data_q <= wr_data_d;
            wr_addr_q <= wr_addr_d;
            wr_en_q   <= wr_en_d;
        end
    end

    assign Wr_Data_o         = wr_data_q;
    assign Wr_Enable_o       = wr_en_q;
    assign write_port_Addr_o = wr_addr_q;
    assign busy_mask_o       = busy_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: expected writes are queued with
// their cycle number and a negedge monitor checks every register write.
module tb_wb_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid_i;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        alu_ready_o;
    logic        ld_valid_i;
    logic [4:0]  ld_rd_i;
    logic [31:0] ld_data_i;
    logic        ld_ready_o;
    logic        pend_set_i;
    logic [4:0]  pend_rd_i;
    logic [31:0] Wr_Data_o;
    logic        Wr_Enable_o;
    logic [4:0]  write_port_Addr_o;
    logic [31:0] busy_mask_o;

    wb_write_arbiter #(.LQ_DEPTH(4), .STARVE_MAX(3)) dut (
        .clk               (clk),
        .rst               (rst),
        .alu_valid_i       (alu_valid_i),
        .alu_rd_i          (alu_rd_i),
        .alu_data_i        (alu_data_i),
        .alu_ready_o       (alu_ready_o),
        .ld_valid_i        (ld_valid_i),
        .ld_rd_i           (ld_rd_i),
        .ld_data_i         (ld_data_i),
        .ld_ready_o        (ld_ready_o),
        .pend_set_i        (pend_set_i),
        .pend_rd_i         (pend_rd_i),
        .Wr_Data_o         (Wr_Data_o),
        .Wr_Enable_o       (Wr_Enable_o),
        .write_port_Addr_o (write_port_Addr_o),
        .busy_mask_o       (busy_mask_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } it_t;

    wr_t exp_q[$];
    wr_t mon_e;
    it_t alu_q[$];
    it_t ld_q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_wr(input int c, input logic [4:0] a,
                          input logic [31:0] d);
        wr_t e;
        e.c = c;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic add_alu(input logic [4:0] rd, input logic [31:0] d);
        it_t t;
        t.rd = rd;
        t.d  = d;
        alu_q.push_back(t);
    endtask

    task automatic add_ld(input logic [4:0] rd, input logic [31:0] d);
        it_t t;
        t.rd = rd;
        t.d  = d;
        ld_q.push_back(t);
    endtask

    // Present queued items with valid/ready handshakes for n cycles;
    // ar/lr hold the expected ready value per cycle (bit i = cycle i)
    task automatic run(input int n, input logic [15:0] ar,
                       input logic [15:0] lr);
        for (int i = 0; i < n; i++) begin
            alu_valid_i = (alu_q.size() != 0);
            ld_valid_i  = (ld_q.size() != 0);
            if (alu_valid_i) begin
                alu_rd_i   = alu_q[0].rd;
                alu_data_i = alu_q[0].d;
            end
            if (ld_valid_i) begin
                ld_rd_i   = ld_q[0].rd;
                ld_data_i = ld_q[0].d;
            end
            if (alu_valid_i) begin
                chk("alu_ready", {31'd0, alu_ready_o}, {31'd0, ar[i]});
                if (alu_ready_o) alu_q.delete(0);
            end
            if (ld_valid_i) begin
                chk("ld_ready", {31'd0, ld_ready_o}, {31'd0, lr[i]});
                if (ld_ready_o) ld_q.delete(0);
            end
            tick();
        end
        alu_valid_i = 1'b0;
        ld_valid_i  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (Wr_Enable_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0d data %h want none (cycle %0d)",
                         write_port_Addr_o, Wr_Data_o, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_cycle", cyc, mon_e.c);
                chk("wr_addr", {27'd0, write_port_Addr_o}, {27'd0, mon_e.a});
                chk("wr_data", Wr_Data_o, mon_e.d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    int s;

    initial begin
        rst         = 1'b0;
        alu_valid_i = 1'b0;
        alu_rd_i    = '0;
        alu_data_i  = '0;
        ld_valid_i  = 1'b0;
        ld_rd_i     = '0;
        ld_data_i   = '0;
        pend_set_i  = 1'b0;
        pend_rd_i   = '0;

        // reset held with live inputs
        repeat (2) tick();
        alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'h1234;
        ld_valid_i  = 1'b1; ld_rd_i  = 5'd6; ld_data_i  = 32'h5678;
        pend_set_i  = 1'b1; pend_rd_i = 5'd4;
        repeat (2) tick();
        chk("rst_wen", {31'd0, Wr_Enable_o}, 32'd0);
        chk("rst_data", Wr_Data_o, 32'd0);
        chk("rst_addr", {27'd0, write_port_Addr_o}, 32'd0);
        chk("rst_busy", busy_mask_o, 32'd0);
        chk("rst_alu_ready", {31'd0, alu_ready_o}, 32'd0);
        chk("rst_ld_ready", {31'd0, ld_ready_o}, 32'd0);
        alu_valid_i = 1'b0;
        ld_valid_i  = 1'b0;
        pend_set_i  = 1'b0;
        rst         = 1'b1;
        tick();
        chk("rel_alu_ready", {31'd0, alu_ready_o}, 32'd1);
        chk("rel_ld_ready", {31'd0, ld_ready_o}, 32'd1);

        // ALU stream rd 1..5
        for (int r = 1; r <= 5; r++) begin
            alu_valid_i = 1'b1;
            alu_rd_i    = 5'(r);
            alu_data_i  = 32'h100 + 32'(r);
            exp_wr(cyc + 1, 5'(r), 32'h100 + 32'(r));
            chk("stream_ready", {31'd0, alu_ready_o}, 32'd1);
            tick();
        end
        alu_valid_i = 1'b0;
        tick();

        // load with idle ALU
        pend_set_i = 1'b1;
        pend_rd_i  = 5'd7;
        tick();
        pend_set_i = 1'b0;
        chk("busy7_set", {31'd0, busy_mask_o[7]}, 32'd1);
        ld_valid_i = 1'b1;
        ld_rd_i    = 5'd7;
        ld_data_i  = 32'hDEADBEEF;
        chk("ld7_ready", {31'd0, ld_ready_o}, 32'd1);
        exp_wr(cyc + 2, 5'd7, 32'hDEADBEEF);
        tick();
        ld_valid_i = 1'b0;
        chk("busy7_pop_cycle", {31'd0, busy_mask_o[7]}, 32'd1);
        tick();
        chk("busy7_clear", {31'd0, busy_mask_o[7]}, 32'd0);
        tick();

        // starvation: one load under continuous ALU traffic
        s = cyc;
        for (int k = 0; k < 6; k++) add_alu(5'(10 + k), 32'hA000_0000 + 32'(k));
        add_ld(5'd9, 32'hBBBB0009);
        exp_wr(s + 1, 5'd10, 32'hA000_0000);
        exp_wr(s + 2, 5'd11, 32'hA000_0001);
        exp_wr(s + 3, 5'd12, 32'hA000_0002);
        exp_wr(s + 4, 5'd13, 32'hA000_0003);
        exp_wr(s + 5, 5'd9,  32'hBBBB0009);
        exp_wr(s + 6, 5'd14, 32'hA000_0004);
        exp_wr(s + 7, 5'd15, 32'hA000_0005);
        run(7, 16'h006F, 16'h0001);
        repeat (3) tick();

        // full FIFO with continuous ALU traffic
        s = cyc;
        for (int k = 0; k < 5; k++) begin
            add_alu(5'(16 + k), 32'hC000_0000 + 32'(k));
            add_ld(5'(21 + k), 32'hD000_0000 + 32'(k));
        end
        exp_wr(s + 1,  5'd16, 32'hC000_0000);
        exp_wr(s + 2,  5'd17, 32'hC000_0001);
        exp_wr(s + 3,  5'd18, 32'hC000_0002);
        exp_wr(s + 4,  5'd19, 32'hC000_0003);
        exp_wr(s + 5,  5'd21, 32'hD000_0000);
        exp_wr(s + 6,  5'd20, 32'hC000_0004);
        exp_wr(s + 7,  5'd22, 32'hD000_0001);
        exp_wr(s + 8,  5'd23, 32'hD000_0002);
        exp_wr(s + 9,  5'd24, 32'hD000_0003);
        exp_wr(s + 10, 5'd25, 32'hD000_0004);
        run(6, 16'h002F, 16'h002F);
        chk("full_ld_ready", {31'd0, ld_ready_o}, 32'd0);
        repeat (6) tick();

        // ALU write to r0 is consumed silently
        alu_valid_i = 1'b1;
        alu_rd_i    = 5'd0;
        alu_data_i  = 32'h55;
        tick();
        alu_valid_i = 1'b0;
        chk("r0_wen", {31'd0, Wr_Enable_o}, 32'd0);
        chk("r0_data", Wr_Data_o, 32'h55);

        // set and clear of the same busy bit in one cycle
        pend_set_i = 1'b1;
        pend_rd_i  = 5'd3;
        tick();
        pend_set_i = 1'b0;
        ld_valid_i = 1'b1;
        ld_rd_i    = 5'd3;
        ld_data_i  = 32'h3333;
        exp_wr(cyc + 2, 5'd3, 32'h3333);
        tick();
        ld_valid_i = 1'b0;
        pend_set_i = 1'b1;
        pend_rd_i  = 5'd3;
        tick();
        pend_set_i = 1'b0;
        chk("collide_busy3", {31'd0, busy_mask_o[3]}, 32'd1);
        tick();
        chk("collide_busy3_hold", {31'd0, busy_mask_o[3]}, 32'd1);

        // reset mid-operation discards the queued load
        alu_valid_i = 1'b1;
        alu_rd_i    = 5'd20;
        alu_data_i  = 32'hE0;
        ld_valid_i  = 1'b1;
        ld_rd_i     = 5'd21;
        ld_data_i   = 32'hE1;
        exp_wr(cyc + 1, 5'd20, 32'hE0);
        tick();
        alu_valid_i = 1'b0;
        ld_valid_i  = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_wen", {31'd0, Wr_Enable_o}, 32'd0);
        chk("midrst_busy", busy_mask_o, 32'd0);
        chk("midrst_alu_ready", {31'd0, alu_ready_o}, 32'd0);
        chk("midrst_ld_ready", {31'd0, ld_ready_o}, 32'd0);
        tick();
        rst = 1'b1;
        repeat (4) tick();

        for (int w = 0; w < 20 && exp_q.size() != 0; w++) tick();
        chk("drain", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
